// File: rtl/hdmi_pkg.sv
// Shared TMDS/HDMI symbol constants: control tokens, video guard bands and the TERC4 table.
// Used by the channel encoders and the data-island/TERC4 path.
package hdmi_pkg;

  typedef enum logic [1:0] {
    CTL_00 = 2'b00,
    CTL_01 = 2'b01,
    CTL_10 = 2'b10,
    CTL_11 = 2'b11
  } ctrl_e;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  localparam logic [9:0] VIDEO_GB_0 = 10'b1011001100;
  localparam logic [9:0] VIDEO_GB_1 = 10'b0100110011;

  function automatic logic [9:0] ctrl_token(input logic [1:0] cd);
    logic [9:0] tok;
    case (ctrl_e'(cd))
      CTL_00:  tok = CTRL_TOKEN_00;
      CTL_01:  tok = CTRL_TOKEN_01;
      CTL_10:  tok = CTRL_TOKEN_10;
      default: tok = CTRL_TOKEN_11;
    endcase
    return tok;
  endfunction

  function automatic logic [9:0] terc4(input logic [3:0] d);
    logic [9:0] sym;
    case (d)
      4'h0:    sym = 10'b1010011100;
      4'h1:    sym = 10'b1001100011;
      4'h2:    sym = 10'b1011100100;
      4'h3:    sym = 10'b1011100010;
      4'h4:    sym = 10'b0101110001;
      4'h5:    sym = 10'b0100011110;
      4'h6:    sym = 10'b0110001110;
      4'h7:    sym = 10'b0100111100;
      4'h8:    sym = 10'b1011001100;
      4'h9:    sym = 10'b0100111001;
      4'hA:    sym = 10'b0110011100;
      4'hB:    sym = 10'b1011000110;
      4'hC:    sym = 10'b1010001110;
      4'hD:    sym = 10'b1001110001;
      4'hE:    sym = 10'b0101100011;
      default: sym = 10'b1011000011;
    endcase
    return sym;
  endfunction

endpackage

// File: rtl/tmds_encoder.sv
// TMDS 8b/10b encoder for one colour channel, two-stage pipeline with running DC balance.
// Stage 1: transition minimisation; stage 2: DC balance / control tokens, registered output.
module tmds_encoder
  import hdmi_pkg::*;
(
  input  logic       I_CLK,
  input  logic       I_RST,
  input  logic [7:0] I_VD,
  input  logic [1:0] I_CD,
  input  logic       I_VDE,
  output logic [9:0] O_TMDS
);

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  logic [3:0]        n1_vd;
  logic              use_xnor;
  logic [8:0]        qm_d, qm_q;
  logic [3:0]        n1q_d, n1q_q;
  logic [1:0]        cd_q;
  logic              vde_q;

  logic signed [4:0] diff;
  logic signed [4:0] cnt_d, cnt_q;
  logic [9:0]        tmds_d, tmds_q;
  logic              q8;
  logic [7:0]        qm8;

  always_comb begin
    n1_vd    = popcount8(I_VD);
    use_xnor = (n1_vd > 4'd4) || ((n1_vd == 4'd4) && !I_VD[0]);
    qm_d     = '0;
    qm_d[0]  = I_VD[0];
    for (int unsigned i = 1; i < 8; i++)
      qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ I_VD[i]) : (qm_d[i-1] ^ I_VD[i]);
    qm_d[8]  = ~use_xnor;
    n1q_d    = popcount8(qm_d[7:0]);
  end

  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      qm_q  <= '0;
      n1q_q <= '0;
      cd_q  <= '0;
      vde_q <= 1'b0;
    end else begin
      qm_q  <= qm_d;
      n1q_q <= n1q_d;
      cd_q  <= I_CD;
      vde_q <= I_VDE;
    end
  end

  // diff = n1q - n0q = 2*n1q - 8, always within -8..8
  assign diff = $signed({n1q_q, 1'b0} - 5'd8);
  assign q8   = qm_q[8];
  assign qm8  = qm_q[7:0];

  always_comb begin
    cnt_d  = '0;
    tmds_d = ctrl_token(cd_q);
    if (vde_q) begin
      if (cnt_q == 5'sd0 || diff == 5'sd0) begin
        tmds_d = {~q8, q8, q8 ? qm8 : ~qm8};
        cnt_d  = q8 ? (cnt_q + diff) : (cnt_q - diff);
      end else if (cnt_q[4] == diff[4]) begin
        // both operands are non-zero here, so equal sign bits mean same polarity
        tmds_d = {1'b1, q8, ~qm8};
        cnt_d  = cnt_q + (q8 ? 5'sd2 : 5'sd0) - diff;
      end else begin
        tmds_d = {1'b0, q8, qm8};
        cnt_d  = cnt_q + diff - (q8 ? 5'sd0 : 5'sd2);
      end
    end
  end

  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      cnt_q  <= '0;
      tmds_q <= CTRL_TOKEN_00;
    end else begin
      cnt_q  <= cnt_d;
      tmds_q <= tmds_d;
    end
  end

  assign O_TMDS = tmds_q;

endmodule

// File: tb/tb_tmds_encoder.sv
// Self-checking bench for tmds_encoder: behavioural TMDS model, per-cycle compare,
// decode round trip, running-disparity bound and transition-count checks.
module tb_tmds_encoder;

  typedef struct {
    logic [9:0] sym;
    bit         vde;
    logic [7:0] vd;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] vd  = '0;
  logic [1:0] cd  = '0;
  logic       vde = 1'b0;
  logic [9:0] tmds;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_cnt    = 0;
  exp_t cur      = '{10'h354, 1'b0, 8'h00};
  exp_t pipe[$];
  bit   done     = 1'b0;

  tmds_encoder dut (
    .I_CLK  (clk),
    .I_RST  (rst),
    .I_VD   (vd),
    .I_CD   (cd),
    .I_VDE  (vde),
    .O_TMDS (tmds)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: the TMDS encoding rules written with plain integers.
  function automatic logic [9:0] ref_encode(input bit v, input logic [7:0] d,
                                            input logic [1:0] c, input int cnt_in,
                                            output int cnt_out);
    int ones, n1, n0;
    bit xn;
    logic [8:0] qm;
    if (!v) begin
      cnt_out = 0;
      case (c)
        2'd0:    return 10'h354;
        2'd1:    return 10'h0AB;
        2'd2:    return 10'h154;
        default: return 10'h2AB;
      endcase
    end
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    xn = (ones > 4) || (ones == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !xn;
    n1 = 0;
    for (int i = 0; i < 8; i++) n1 += int'(qm[i]);
    n0 = 8 - n1;
    if (cnt_in == 0 || n1 == n0) begin
      cnt_out = cnt_in + (qm[8] ? (n1 - n0) : (n0 - n1));
      return qm[8] ? {2'b01, qm[7:0]} : {2'b10, ~qm[7:0]};
    end else if ((cnt_in > 0 && n1 > n0) || (cnt_in < 0 && n0 > n1)) begin
      cnt_out = cnt_in + 2 * int'(qm[8]) + n0 - n1;
      return {1'b1, qm[8], ~qm[7:0]};
    end
    cnt_out = cnt_in + n1 - n0 - 2 * (1 - int'(qm[8]));
    return {1'b0, qm[8], qm[7:0]};
  endfunction

  function automatic logic [7:0] ref_decode(input logic [9:0] s);
    logic [7:0] d8, o;
    d8 = s[9] ? ~s[7:0] : s[7:0];
    o[0] = d8[0];
    for (int i = 1; i < 8; i++) o[i] = s[8] ? (d8[i] ^ d8[i-1]) : ~(d8[i] ^ d8[i-1]);
    return o;
  endfunction

  task automatic drive(input bit v, input logic [7:0] d, input logic [1:0] c);
    int nc;
    @(negedge clk);
    rst = 1'b0;
    vde = v;
    vd  = d;
    cd  = c;
    cur.sym = ref_encode(v, d, c, m_cnt, nc);
    cur.vde = v;
    cur.vd  = d;
    m_cnt   = nc;
  endtask

  task automatic pulse_reset(input int cycles);
    @(negedge clk);
    rst   = 1'b1;
    m_cnt = 0;
    #1 chk("rst_async", int'(tmds), 'h354);
    repeat (cycles) @(posedge clk);
  endtask

  // Single compare process: DUT output after edge S reflects the input sampled at S-1.
  initial begin
    int disp, ones, trans;
    exp_t e;
    disp = 0;
    while (!done) begin
      @(posedge clk);
      if (rst) begin
        pipe.delete();
        pipe.push_back('{10'h354, 1'b0, 8'h00});
        disp = 0;
        #1 chk("reset_out", int'(tmds), 'h354);
      end else begin
        pipe.push_back(cur);
        #1;
        e = pipe.pop_front();
        chk("symbol", int'(tmds), int'(e.sym));
        if (e.vde) begin
          chk("decode", int'(ref_decode(tmds)), int'(e.vd));
          ones = 0;
          trans = 0;
          for (int i = 0; i < 10; i++) ones += int'(tmds[i]);
          for (int i = 1; i < 10; i++) trans += int'(tmds[i] != tmds[i-1]);
          disp += 2 * ones - 10;
          chk("disp_bound", int'(disp >= -10 && disp <= 10), 1);
          chk("transitions", int'(trans <= 5), 1);
        end else begin
          disp = 0;
        end
      end
    end
  end

  initial begin
    int c1, c2;
    logic [9:0] s;
    bit rv;

    // Pin the reference model with hand-derived symbols.
    s = ref_encode(1'b1, 8'h00, 2'd0, 0, c1);
    chk("lit_00_a", int'(s), 'h100);  chk("lit_00_a_cnt", c1, -8);
    s = ref_encode(1'b1, 8'h00, 2'd0, c1, c2);
    chk("lit_00_b", int'(s), 'h3FF);  chk("lit_00_b_cnt", c2, 2);
    s = ref_encode(1'b1, 8'h00, 2'd0, c2, c1);
    chk("lit_00_c", int'(s), 'h100);  chk("lit_00_c_cnt", c1, -6);
    s = ref_encode(1'b1, 8'hFF, 2'd0, 0, c1);
    chk("lit_ff", int'(s), 'h200);    chk("lit_ff_cnt", c1, -8);
    s = ref_encode(1'b0, 8'hFF, 2'd2, 4, c1);
    chk("lit_tok10", int'(s), 'h154); chk("lit_tok_cnt", c1, 0);

    repeat (3) @(posedge clk);

    for (int i = 0; i < 4; i++) drive(1'b0, 8'($urandom), 2'(i));
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h00, 2'($urandom));
    drive(1'b0, 8'h00, 2'd0);
    drive(1'b1, 8'hFF, 2'd3);
    drive(1'b0, 8'h00, 2'd1);
    drive(1'b1, 8'hFF, 2'd0);
    drive(1'b0, 8'h00, 2'd0);

    for (int i = 0; i < 6; i++) drive(1'b1, 8'($urandom), 2'd0);
    pulse_reset(2);
    for (int i = 0; i < 4; i++) drive(1'b1, 8'($urandom), 2'd0);
    pulse_reset(0);

    for (int i = 0; i < 10000; i++) begin
      rv = ($urandom_range(0, 15) != 0);
      drive(rv, 8'($urandom), 2'($urandom));
    end
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 2'd0);

    repeat (2) @(posedge clk);
    done = 1'b1;
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
